// File: rtl/safe_lock_if.sv
// Operator-side bundle for the safe lock controller.
// master: dial/commit/lock/door/prog inputs; slave: display and status outputs.
interface safe_lock_if #(
  parameter int DIGITS   = 3,
  parameter int MAX_FAIL = 3
);
  localparam int IW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic          cnten;
  logic          up;
  logic          dirch;
  logic          lock;
  logic          door_cls;
  logic          prog;
  logic [3:0]    bcd1;
  logic [3:0]    bcd0;
  logic          blank;
  logic          actuate_lock;
  logic          safe_open;
  logic          lockout;
  logic [IW-1:0] digit_idx;
  logic [FW-1:0] fail_cnt;

  modport master (
    output cnten, up, dirch, lock, door_cls, prog,
    input  bcd1, bcd0, blank, actuate_lock, safe_open,
    input  lockout, digit_idx, fail_cnt
  );

  modport slave (
    input  cnten, up, dirch, lock, door_cls, prog,
    output bcd1, bcd0, blank, actuate_lock, safe_open,
    output lockout, digit_idx, fail_cnt
  );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Combination safe controller: BCD dial, code check, lockout, relock, reprogram.
// Ports: clk, reset (async high), bus (safe_lock_if.slave) with dial inputs and status.
module safe_lock_ctrl #(
  parameter int                  DIGITS        = 3,
  parameter logic [8*DIGITS-1:0] CODE_INIT     = 24'h123456,
  parameter int                  MAX_FAIL      = 3,
  parameter int                  LOCKOUT_TICKS = 5000,
  parameter int                  ENTRY_TIMEOUT = 10000,
  parameter int                  RELOCK_TICKS  = 20000
) (
  input logic        clk,
  input logic        reset,
  safe_lock_if.slave bus
);
  localparam int IW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int T1 = (LOCKOUT_TICKS > ENTRY_TIMEOUT) ?
                      LOCKOUT_TICKS : ENTRY_TIMEOUT;
  localparam int TMAX = (T1 > RELOCK_TICKS) ? T1 : RELOCK_TICKS;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    LOCKED, ENTRY, UNLOCKED, DOOR_OPEN, PROGRAM, LOCKOUT
  } state_t;

  state_t        state, ns;
  logic [3:0]    tens, units, tens_n, units_n;
  logic [IW-1:0] idx, idx_n;
  logic [FW-1:0] fail_q, fail_n;
  logic          mis, mis_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [7:0]    code [DIGITS];
  logic [7:0]    code_n [DIGITS];
  logic [7:0]    shadow [DIGITS];
  logic [7:0]    shadow_n [DIGITS];
  logic [7:0]    dial, dial_inc, dial_dec;
  logic [AW-1:0] slot;
  logic          commit, step, last, bad;
  logic          blank_q, act_q, open_q, lo_q;

  assign dial = {tens, units};
  assign slot = idx[AW-1:0];
  assign last = (idx == IW'(DIGITS - 1));
  assign bad  = mis || (dial != code[slot]);

  always_comb begin
    dial_inc = {tens, units + 4'd1};
    if (units == 4'd9)
      dial_inc = {(tens == 4'd9) ? 4'd0 : tens + 4'd1, 4'd0};
    dial_dec = {tens, units - 4'd1};
    if (units == 4'd0)
      dial_dec = {(tens == 4'd0) ? 4'd9 : tens - 4'd1, 4'd9};
  end

  // A commit takes the pre-cycle dial and swallows a coincident step.
  always_comb begin
    ns       = state;
    tens_n   = tens;
    units_n  = units;
    idx_n    = idx;
    fail_n   = fail_q;
    mis_n    = mis;
    tmr_n    = '0;
    code_n   = code;
    shadow_n = shadow;
    commit   = bus.dirch && (state == ENTRY || state == PROGRAM);
    step     = bus.cnten && !commit &&
               (state == LOCKED || state == ENTRY ||
                state == PROGRAM);
    if (step)
      {tens_n, units_n} = bus.up ? dial_inc : dial_dec;
    if (commit) begin
      {tens_n, units_n} = 8'h00;
      idx_n = idx + 1'b1;
    end
    unique case (state)
      LOCKED: begin
        if (bus.cnten) ns = ENTRY;
      end
      ENTRY: begin
        if (commit) begin
          mis_n = bad;
          if (last) begin
            idx_n = '0;
            mis_n = 1'b0;
            if (!bad) begin
              ns     = UNLOCKED;
              fail_n = '0;
            end else begin
              fail_n = fail_q + 1'b1;
              ns = (int'(fail_q) + 1 == MAX_FAIL) ?
                   LOCKOUT : LOCKED;
            end
          end
        end else if (!bus.cnten) begin
          if (tmr == TW'(ENTRY_TIMEOUT - 1)) begin
            ns                = LOCKED;
            {tens_n, units_n} = 8'h00;
            idx_n             = '0;
            mis_n             = 1'b0;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
      end
      UNLOCKED: begin
        unique case (1'b1)
          !bus.door_cls: ns = DOOR_OPEN;
          bus.lock:      ns = LOCKED;
          bus.prog: begin
            ns    = PROGRAM;
            idx_n = '0;
          end
          default: begin
            if (tmr == TW'(RELOCK_TICKS - 1)) ns = LOCKED;
            else tmr_n = tmr + 1'b1;
          end
        endcase
      end
      DOOR_OPEN: begin
        if (bus.door_cls) ns = UNLOCKED;
      end
      PROGRAM: begin
        if (!bus.door_cls) begin
          ns                = DOOR_OPEN;
          {tens_n, units_n} = 8'h00;
          idx_n             = '0;
        end else if (commit) begin
          shadow_n[slot] = dial;
          if (last) begin
            code_n = shadow_n;
            idx_n  = '0;
            ns     = UNLOCKED;
          end
        end
      end
      LOCKOUT: begin
        if (tmr == TW'(LOCKOUT_TICKS - 1)) begin
          ns     = LOCKED;
          fail_n = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: ns = LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LOCKED;
      tens    <= 4'd0;
      units   <= 4'd0;
      idx     <= '0;
      fail_q  <= '0;
      mis     <= 1'b0;
      tmr     <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        code[k]   <= CODE_INIT[8*(DIGITS-1-k) +: 8];
        shadow[k] <= 8'h00;
      end
      blank_q <= 1'b0;
      act_q   <= 1'b1;
      open_q  <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state   <= ns;
      tens    <= tens_n;
      units   <= units_n;
      idx     <= idx_n;
      fail_q  <= fail_n;
      mis     <= mis_n;
      tmr     <= tmr_n;
      code    <= code_n;
      shadow  <= shadow_n;
      blank_q <= (ns == UNLOCKED) || (ns == DOOR_OPEN) ||
                 (ns == LOCKOUT);
      act_q   <= (ns == LOCKED) || (ns == ENTRY) ||
                 (ns == LOCKOUT);
      open_q  <= !((ns == LOCKED) || (ns == ENTRY) ||
                   (ns == LOCKOUT));
      lo_q    <= (ns == LOCKOUT);
    end
  end

  assign bus.bcd1         = tens;
  assign bus.bcd0         = units;
  assign bus.digit_idx    = idx;
  assign bus.fail_cnt     = fail_q;
  assign bus.blank        = blank_q;
  assign bus.actuate_lock = act_q;
  assign bus.safe_open    = open_q;
  assign bus.lockout      = lo_q;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Self-checking bench for safe_lock_ctrl.
// Directed table, corner sequences, and random traffic against a reference model.
module tb_safe_lock_ctrl;
  localparam int DIGITS = 3;
  localparam int MAX_FAIL = 3;
  localparam int LT = 20;
  localparam int ET = 30;
  localparam int RT = 40;
  localparam int IW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  safe_lock_if #(.DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL)) bus ();

  safe_lock_ctrl #(
    .DIGITS(DIGITS), .CODE_INIT(24'h123456), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_TICKS(LT), .ENTRY_TIMEOUT(ET), .RELOCK_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Reference model: dial as an integer 0..99, entries kept in a queue.
  typedef enum {M_LOCKED, M_ENTRY, M_UNLOCKED,
                M_DOOR, M_PROG, M_LOCKOUT} mst_t;
  mst_t ms;
  int   m_dial, m_fail, m_cnt;
  int   m_code [DIGITS];
  int   m_q [$];

  function automatic int stepd(int v, bit u);
    return u ? (v + 1) % 100 : (v + 99) % 100;
  endfunction

  function automatic bit q_matches();
    for (int k = 0; k < DIGITS; k++)
      if (m_q[k] != m_code[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    ms = M_LOCKED;
    m_dial = 0;
    m_fail = 0;
    m_cnt = 0;
    m_q.delete();
    m_code = '{12, 34, 56};
  endtask

  task automatic m_step(input bit c, u, d, l, dc, p);
    case (ms)
      M_LOCKED: if (c) begin
        m_dial = stepd(m_dial, u);
        ms = M_ENTRY;
        m_cnt = 0;
      end
      M_ENTRY: begin
        if (d) begin
          m_q.push_back(m_dial);
          m_dial = 0;
          m_cnt = 0;
          if (m_q.size() == DIGITS) begin
            if (q_matches()) begin
              ms = M_UNLOCKED;
              m_fail = 0;
            end else begin
              m_fail++;
              ms = (m_fail == MAX_FAIL) ? M_LOCKOUT : M_LOCKED;
            end
            m_q.delete();
          end
        end else if (c) begin
          m_dial = stepd(m_dial, u);
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == ET) begin
            ms = M_LOCKED;
            m_dial = 0;
            m_q.delete();
          end
        end
      end
      M_UNLOCKED: begin
        if (!dc) ms = M_DOOR;
        else if (l) ms = M_LOCKED;
        else if (p) ms = M_PROG;
        else begin
          m_cnt++;
          if (m_cnt == RT) ms = M_LOCKED;
        end
      end
      M_DOOR: if (dc) begin
        ms = M_UNLOCKED;
        m_cnt = 0;
      end
      M_PROG: begin
        if (!dc) begin
          ms = M_DOOR;
          m_dial = 0;
          m_q.delete();
        end else if (d) begin
          m_q.push_back(m_dial);
          m_dial = 0;
          if (m_q.size() == DIGITS) begin
            for (int k = 0; k < DIGITS; k++) m_code[k] = m_q[k];
            m_q.delete();
            ms = M_UNLOCKED;
            m_cnt = 0;
          end
        end else if (c) begin
          m_dial = stepd(m_dial, u);
        end
      end
      M_LOCKOUT: begin
        m_cnt++;
        if (m_cnt == LT) begin
          ms = M_LOCKED;
          m_fail = 0;
        end
      end
      default: ms = M_LOCKED;
    endcase
  endtask

  function automatic logic [15:0] m_out();
    bit act, blk;
    act = (ms == M_LOCKED) || (ms == M_ENTRY) || (ms == M_LOCKOUT);
    blk = (ms == M_UNLOCKED) || (ms == M_DOOR) || (ms == M_LOCKOUT);
    return {4'(m_dial / 10), 4'(m_dial % 10), blk, act, !act,
            ms == M_LOCKOUT, IW'(m_q.size()), FW'(m_fail)};
  endfunction

  function automatic logic [15:0] dut_out();
    return {bus.bcd1, bus.bcd0, bus.blank, bus.actuate_lock,
            bus.safe_open, bus.lockout, bus.digit_idx, bus.fail_cnt};
  endfunction

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp,
               $time);
    end
  endfunction

  task automatic cyc(input bit c, u, d, l, dc, p);
    bus.cnten = c;
    bus.up = u;
    bus.dirch = d;
    bus.lock = l;
    bus.door_cls = dc;
    bus.prog = p;
    @(posedge clk);
    m_step(c, u, d, l, dc, p);
    #1;
    chk("model", 32'(dut_out()), 32'(m_out()));
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst_model", 32'(dut_out()), 32'(m_out()));
    chk("rst_act", 32'(bus.actuate_lock), 32'd1);
    chk("rst_open", 32'(bus.safe_open), 32'd0);
    chk("rst_blank", 32'(bus.blank), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  task automatic dial_to(input int target, input bit dir);
    int n;
    n = dir ? (target - m_dial + 100) % 100
            : (m_dial - target + 100) % 100;
    repeat (n) cyc(1, dir, 0, 0, 1, 0);
  endtask

  task automatic commit();
    cyc(0, 0, 1, 0, 1, 0);
  endtask

  task automatic enter_code(input int a, b, c);
    dial_to(a, 1); commit();
    dial_to(b, 1); commit();
    dial_to(c, 1); commit();
  endtask

  typedef struct {
    int rep;
    bit c, u, d, l, dc, p;
    int ed, ei, ef;
    bit eo, el;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input int rep, input bit c, u, d, l, dc, p,
                     input int ed, ei, ef, input bit eo, el);
    vec_t v;
    v = '{rep, c, u, d, l, dc, p, ed, ei, ef, eo, el};
    tbl.push_back(v);
  endtask

  // Three nonzero digits dialled up from 00 and committed.
  task automatic add_code(input int a, b, c, input bit od,
                          input int fb, fa, input bit oa, la);
    add(a, 1, 1, 0, 0, 1, 0, a, 0, fb, od, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 1, fb, od, 0);
    add(b, 1, 1, 0, 0, 1, 0, b, 1, fb, od, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 2, fb, od, 0);
    add(c, 1, 1, 0, 0, 1, 0, c, 2, fb, od, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, fa, oa, la);
  endtask

  task automatic lock_rec();
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int mode, n, pk;
    bit dir;
    reset = 1'b1;
    bus.cnten = 0; bus.up = 0; bus.dirch = 0;
    bus.lock = 0; bus.door_cls = 1; bus.prog = 0;
    m_reset();
    #8;
    chk("init_model", 32'(dut_out()), 32'(m_out()));
    #1;
    reset = 1'b0;

    add_code(12, 34, 56, 0, 0, 0, 1, 0);
    lock_rec();
    add_code(12, 34, 57, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 99, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    add(ET - 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add_code(12, 34, 57, 0, 1, 2, 0, 0);
    add_code(12, 34, 57, 0, 2, 3, 0, 1);
    add(LT - 1, 1, 1, 1, 1, 1, 1, 0, 0, 3, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(12, 1, 1, 0, 0, 1, 0, 12, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    add(34, 1, 1, 0, 0, 1, 0, 34, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0, 0);
    add(56, 1, 1, 0, 0, 1, 0, 56, 2, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    add_code(1, 2, 3, 1, 0, 0, 1, 0);
    lock_rec();
    add_code(12, 34, 56, 0, 0, 1, 0, 0);
    add_code(1, 2, 3, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(9, 1, 1, 0, 0, 1, 0, 9, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add_code(12, 34, 56, 0, 0, 0, 1, 0);
    lock_rec();

    foreach (tbl[i]) begin
      if (tbl[i].rep == 0) do_reset();
      else for (int r = 0; r < tbl[i].rep; r++)
        cyc(tbl[i].c, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].dc,
            tbl[i].p);
      chk($sformatf("vec%0d_dial", i), 32'({bus.bcd1, bus.bcd0}),
          32'({4'(tbl[i].ed / 10), 4'(tbl[i].ed % 10)}));
      chk($sformatf("vec%0d_idx", i), 32'(bus.digit_idx),
          32'(tbl[i].ei));
      chk($sformatf("vec%0d_fail", i), 32'(bus.fail_cnt),
          32'(tbl[i].ef));
      chk($sformatf("vec%0d_open", i), 32'(bus.safe_open),
          32'(tbl[i].eo));
      chk($sformatf("vec%0d_lockout", i), 32'(bus.lockout),
          32'(tbl[i].el));
    end

    cyc(0, 0, 1, 0, 1, 0);
    chk("locked_dirch_idx", 32'(bus.digit_idx), 32'd0);
    enter_code(12, 34, 56);
    cyc(0, 0, 0, 0, 0, 0);
    chk("door_blank", 32'(bus.blank), 32'd1);
    repeat (5) cyc(0, 0, 0, 1, 0, 1);
    chk("door_ignores", 32'({bus.safe_open, bus.actuate_lock}),
        32'b10);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (RT - 1) cyc(0, 0, 0, 0, 1, 0);
    chk("relock_early", 32'(bus.actuate_lock), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("relock_due", 32'(bus.actuate_lock), 32'd1);
    enter_code(12, 34, 56);
    cyc(0, 0, 0, 0, 1, 1);
    dial_to(7, 1);
    commit();
    cyc(0, 0, 0, 0, 0, 0);
    chk("abort_idx", 32'(bus.digit_idx), 32'd0);
    chk("abort_dial", 32'({bus.bcd1, bus.bcd0}), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    enter_code(12, 34, 56);
    chk("abort_code_kept", 32'(bus.safe_open), 32'd1);
    cyc(0, 0, 0, 1, 1, 0);

    for (int it = 0; it < 60; it++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          pk = $urandom_range(0, 2 * DIGITS - 1);
          for (int k = 0; k < DIGITS; k++) begin
            n = m_code[k];
            if (k == pk) n = (n + 1) % 100;
            dir = 1'($urandom_range(0, 1));
            dial_to(n, dir);
            commit();
          end
        end
        1: begin
          n = $urandom_range(1, 50);
          repeat (n)
            cyc(($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 15) != 0),
                ($urandom_range(0, 15) == 0));
        end
        2: begin
          enter_code(m_code[0], m_code[1], m_code[2]);
          cyc(0, 0, 0, 0, 1, 1);
          for (int k = 0; k < DIGITS; k++) begin
            dial_to($urandom_range(0, 99), 1'($urandom_range(0, 1)));
            commit();
          end
          cyc(0, 0, 0, 1, 1, 0);
        end
        default: begin
          n = $urandom_range(ET - 5, RT + 5);
          repeat (n) cyc(0, 0, 0, 0, 1, 0);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/safe_lock_ctrl.md
SAFE_LOCK_CTRL -- requirements
Module: safe_lock_ctrl

Parameters
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- DIGITS, 3, number of two-digit BCD entries in the combination (1..8).
- CODE_INIT, 24'h123456, reset combination, DIGITS*8 bits, entry k = CODE_INIT[8*(DIGITS-1-k) +: 8].
- MAX_FAIL, 3, failed attempts that trigger lockout (>=1).
- LOCKOUT_TICKS, 5000, lockout duration in clk cycles.
- ENTRY_TIMEOUT, 10000, idle cycles after which a partial entry is abandoned.
- RELOCK_TICKS, 20000, cycles in UNLOCKED with door closed before automatic relock.

Interface
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock (1 ms tick domain).
- reset, in, 1, asynchronous active-high reset.
- cnten, in, 1, one-cycle dial step pulse.
- up, in, 1, step direction: 1 = increment, 0 = decrement.
- dirch, in, 1, one-cycle commit pulse for the current dial value.
- lock, in, 1, relock request.
- door_cls, in, 1, door closed sensor, 1 = closed.
- prog, in, 1, pulse that starts code reprogramming.
- bcd1, out, 4, dial tens digit.
- bcd0, out, 4, dial units digit.
- blank, out, 1, display blank.
- actuate_lock, out, 1, bolt engaged.
- safe_open, out, 1, unlocked indicator.
- lockout, out, 1, lockout active.
- digit_idx, out, clog2(DIGITS+1), count of committed entries.
- fail_cnt, out, clog2(MAX_FAIL+1), consecutive failed attempts.

Function
REQ-003 The dial SHALL be a two-digit BCD counter, 00..99; cnten&up increments with 99->00 wrap, cnten&!up decrements with 00->99 wrap, and it is active only in LOCKED, ENTRY and PROGRAM.
REQ-004 When cnten and dirch coincide, the block SHALL commit the pre-cycle dial value and ignore cnten that cycle.
REQ-005 Every commit SHALL clear the dial to 00 and increment digit_idx on the next cycle.
REQ-006 The FSM SHALL have states LOCKED, ENTRY, UNLOCKED, DOOR_OPEN, PROGRAM and LOCKOUT, all registered; outputs SHALL be decoded from registered state.
REQ-007 LOCKED: the first cnten SHALL apply its step and move to ENTRY; dirch in LOCKED SHALL be ignored.
REQ-008 ENTRY: each commit SHALL compare the dial with code entry digit_idx and set a sticky mismatch flag on inequality; the verdict SHALL wait until DIGITS commits, so no early-fail information leaks.
REQ-009 After the DIGITS-th commit, the block SHALL go to UNLOCKED with fail_cnt cleared if no mismatch; otherwise it SHALL increment fail_cnt and go to LOCKOUT if fail_cnt reaches MAX_FAIL, else to LOCKED; digit_idx and the mismatch flag SHALL be cleared in all cases.
REQ-010 ENTRY_TIMEOUT cycles in ENTRY without cnten or dirch SHALL return the block to LOCKED with dial 00 and digit_idx 0, and fail_cnt unchanged.
REQ-011 UNLOCKED: actuate_lock=0 and safe_open=1; door_cls=0 SHALL go to DOOR_OPEN; lock with door_cls=1 SHALL go to LOCKED; prog SHALL go to PROGRAM; RELOCK_TICKS consecutive cycles with door_cls=1 SHALL go to LOCKED. Priority is door_cls=0, then lock, then prog, then timeout.
REQ-012 DOOR_OPEN: lock and prog SHALL be ignored; door_cls=1 SHALL return to UNLOCKED and restart the relock timer.
REQ-013 PROGRAM: commits SHALL load a shadow register; after DIGITS commits the shadow SHALL be copied to the code in one cycle and the block SHALL return to UNLOCKED; door_cls=0 SHALL abort to DOOR_OPEN and leave the code unchanged.
REQ-014 LOCKOUT: lockout=1, blank=1, all inputs ignored; after LOCKOUT_TICKS cycles the block SHALL go to LOCKED with fail_cnt=0.
REQ-015 blank SHALL be 1 in UNLOCKED, DOOR_OPEN and LOCKOUT, and 0 otherwise.
REQ-016 actuate_lock SHALL be 1 in LOCKED, ENTRY and LOCKOUT.

Reset
REQ-017 When reset is asserted, the block SHALL asynchronously enter LOCKED with dial=00, digit_idx=0, fail_cnt=0, mismatch=0, all timers=0, code=CODE_INIT, actuate_lock=1, safe_open=0, lockout=0 and blank=0; reset mid-entry or mid-program SHALL discard any partial data.

Verification
REQ-018 The bench SHALL cover these directed scenarios with defaults, LOCKOUT_TICKS=20, ENTRY_TIMEOUT=30 and RELOCK_TICKS=40:
- Dial 12, commit; 34, commit; 56, commit -> safe_open=1, actuate_lock=0, fail_cnt=0.
- Three attempts with 12,34,57 -> fail_cnt goes 1, 2, then lockout=1 for 20 cycles, then LOCKED with fail_cnt=0.
- Dial down 1 from 00 -> dial 99; up 1 from 99 -> dial 00.
- cnten and dirch in the same cycle at dial 12 -> 12 committed, dial 00.
- Unlock, prog, enter 01,02,03, then lock -> 12,34,56 fails and 01,02,03 unlocks.
- Mid-entry idle 30 cycles -> LOCKED, digit_idx=0; reset mid-PROGRAM -> code=CODE_INIT.
